argmax_top2: RTL and testbench

Parametrised streaming argmax for the Tsetlin Machine classifier back end. It accepts one signed class summation per beat over a valid/ready handshake and tracks the winning class and the runner-up. At the end of each frame it presents the winner, the runner-up, the winning score and the confidence margin on a registered valid/ready result port. It sits between the class-summation stage and the result/SPI readout, and supports wider sums, more classes, backpressure, flush and sequence checking.

---
 rtl/argmax_top2.sv | 165 ++++++++++++++++
 tb/tb_argmax_top2.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/argmax_top2.sv
// argmax_top2: streaming argmax over one frame of signed class sums, reporting winner and runner-up.
// Optional runner-up tracker and margin subtractor are built only when ARGMAX_MARGIN_EN is defined.
module argmax_top2 #(
   parameter int SUM_W     = 14,
   parameter int CLS_W     = 4,
   parameter int MAX_CLASS = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CLS_W:0]   cfg_num_class,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [SUM_W-1:0] in_sum,
   input  logic [CLS_W-1:0] in_idx,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CLS_W-1:0] out_class,
   output logic [CLS_W-1:0] out_second,
   output logic [SUM_W-1:0] out_max_sum,
   output logic [SUM_W-1:0] out_margin,
   output logic             out_err
);

   localparam logic [SUM_W-1:0] S_MIN    = {1'b1, {(SUM_W-1){1'b0}}};
   localparam logic [CLS_W:0]   NCLS_MAX = (CLS_W+1)'(MAX_CLASS);
   localparam logic [CLS_W:0]   NCLS_MIN = (CLS_W+1)'(2);
   localparam logic [CLS_W:0]   ONE      = (CLS_W+1)'(1);

   typedef enum logic {COLLECT = 1'b0, RESULT = 1'b1} state_t;
   state_t state, state_nxt;

   logic [CLS_W:0]   cnt, ncls_q, cfg_clamped, ncls_cur;
   logic             err_f, accept, last, idx_err;
   logic [SUM_W-1:0] max_s, nmax_s;
   logic [CLS_W-1:0] max_i, nmax_i;
`ifdef ARGMAX_MARGIN_EN
   logic [SUM_W-1:0] sec_s, nsec_s;
   logic [CLS_W-1:0] sec_i, nsec_i;
`endif

   assign accept   = in_valid && in_ready && !flush;
   assign ncls_cur = (cnt == '0) ? cfg_clamped : ncls_q;
   assign last     = (cnt == ncls_cur - ONE);
   assign idx_err  = ({1'b0, in_idx} != cnt);

   always_comb begin
      cfg_clamped = cfg_num_class;
      if (cfg_num_class < NCLS_MIN)
         cfg_clamped = NCLS_MIN;
      else if (cfg_num_class > NCLS_MAX)
         cfg_clamped = NCLS_MAX;
   end

   // Strict greater-than only: ties keep the earlier arrival in both slots.
   always_comb begin
      nmax_s = max_s;
      nmax_i = max_i;
`ifdef ARGMAX_MARGIN_EN
      nsec_s = sec_s;
      nsec_i = sec_i;
      if ($signed(in_sum) > $signed(max_s)) begin
         nsec_s = max_s;
         nsec_i = max_i;
         nmax_s = in_sum;
         nmax_i = in_idx;
      end else if ($signed(in_sum) > $signed(sec_s)) begin
         nsec_s = in_sum;
         nsec_i = in_idx;
      end
`else
      if ($signed(in_sum) > $signed(max_s)) begin
         nmax_s = in_sum;
         nmax_i = in_idx;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= COLLECT;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (flush)
         state_nxt = COLLECT;
      else begin
         case (state)
            COLLECT: if (accept && last) state_nxt = RESULT;
            RESULT:  if (out_ready)      state_nxt = COLLECT;
            default: state_nxt = COLLECT;
         endcase
      end
   end

   always_comb begin
      in_ready  = (state == COLLECT) && !rst;
      out_valid = (state == RESULT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt         <= '0;
         ncls_q      <= NCLS_MIN;
         err_f       <= 1'b0;
         max_s       <= S_MIN;
         max_i       <= '0;
         out_class   <= '0;
         out_max_sum <= '0;
         out_err     <= 1'b0;
`ifdef ARGMAX_MARGIN_EN
         sec_s       <= S_MIN;
         sec_i       <= '0;
         out_second  <= '0;
         out_margin  <= '0;
`endif
      end else if (flush) begin
         cnt   <= '0;
         err_f <= 1'b0;
         max_s <= S_MIN;
         max_i <= '0;
`ifdef ARGMAX_MARGIN_EN
         sec_s <= S_MIN;
         sec_i <= '0;
`endif
      end else if (accept) begin
         if (cnt == '0)
            ncls_q <= cfg_clamped;
         if (last) begin
            out_class   <= nmax_i;
            out_max_sum <= nmax_s;
            out_err     <= err_f | idx_err;
            cnt         <= '0;
            err_f       <= 1'b0;
            max_s       <= S_MIN;
            max_i       <= '0;
`ifdef ARGMAX_MARGIN_EN
            // max never falls below sec, so the widened difference always fits unsigned SUM_W.
            out_second  <= nsec_i;
            out_margin  <= SUM_W'({nmax_s[SUM_W-1], nmax_s} - {nsec_s[SUM_W-1], nsec_s});
            sec_s       <= S_MIN;
            sec_i       <= '0;
`endif
         end else begin
            cnt   <= cnt + ONE;
            err_f <= err_f | idx_err;
            max_s <= nmax_s;
            max_i <= nmax_i;
`ifdef ARGMAX_MARGIN_EN
            sec_s <= nsec_s;
            sec_i <= nsec_i;
`endif
         end
      end
   end

`ifndef ARGMAX_MARGIN_EN
   assign out_second = '0;
   assign out_margin = '0;
`endif

endmodule

// File: tb/tb_argmax_top2.sv
// Randomised + directed bench for argmax_top2 against a whole-frame reference model.
module tb_argmax_top2;
   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_err;
   logic [4:0]  cfg_num_class;
   logic [13:0] in_sum, out_max_sum, out_margin;
   logic [3:0]  in_idx, out_class, out_second;

   int checks = 0;
   int failures = 0;
   logic [13:0] f_sum [32];
   logic [3:0]  f_idx [32];
   int e_cls, e_sec, e_max, e_mar, e_err;

   always #5 clk = ~clk;

   argmax_top2 dut (
      .clk(clk), .rst(rst), .cfg_num_class(cfg_num_class), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum), .in_idx(in_idx),
      .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
      .out_second(out_second), .out_max_sum(out_max_sum), .out_margin(out_margin),
      .out_err(out_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int sv(input logic [13:0] x);
      return int'($signed(x));
   endfunction

   function automatic int clampn(input int c);
      return (c < 2) ? 2 : ((c > 16) ? 16 : c);
   endfunction

   // Winner: first arrival holding the frame maximum; runner-up: first arrival holding the
   // maximum of all other beats. A value equal to the most-negative sentinel never displaces it.
   function automatic void model(input int n);
      int mx, sm, wpos, spos;
      mx = -8192; sm = -8192; wpos = 0; spos = -1; e_err = 0;
      for (int k = 0; k < n; k++) if (sv(f_sum[k]) > mx) mx = sv(f_sum[k]);
      for (int k = n - 1; k >= 0; k--) if (sv(f_sum[k]) == mx) wpos = k;
      for (int k = 0; k < n; k++) if (k != wpos && sv(f_sum[k]) > sm) sm = sv(f_sum[k]);
      for (int k = n - 1; k >= 0; k--) if (k != wpos && sv(f_sum[k]) == sm) spos = k;
      for (int k = 0; k < n; k++) if (int'(f_idx[k]) != k) e_err = 1;
      e_cls = (mx == -8192) ? 0 : int'(f_idx[wpos]);
      e_sec = (sm == -8192 || spos < 0) ? 0 : int'(f_idx[spos]);
      e_max = mx;
      e_mar = mx - sm;
   endfunction

   task automatic beat(input int cfg, input logic [13:0] s, input logic [3:0] i);
      cfg_num_class = 5'(cfg);
      in_valid = 1'b1;
      in_sum = s;
      in_idx = i;
      check("beat_in_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic fill(input int n, input bit mk_err);
      int r, pos;
      for (int k = 0; k < 32; k++) begin
         r = int'($urandom_range(0, 15));
         f_sum[k] = (r == 0) ? 14'h2000 : (r == 1) ? 14'h1fff : 14'($urandom_range(0, 10)) - 14'd5;
         f_idx[k] = 4'(k);
      end
      if (mk_err) begin
         pos = int'($urandom_range(0, n - 1));
         f_idx[pos] = f_idx[pos] + 4'd1;
      end
   endtask

   task automatic run_frame(input int cfg, input int hold, input bit do_rst);
      int n;
      logic [31:0] ecls, emax;
      n = clampn(cfg);
      model(n);
      ecls = 32'(e_cls[3:0]);
      emax = 32'(e_max[13:0]);
      out_ready = (hold == 0);
      for (int k = 0; k < n; k++) begin
         beat((k == 0) ? cfg : int'($urandom_range(0, 31)), f_sum[k], f_idx[k]);
         if (k == n - 2) check("early_valid", out_valid, 0);
      end
      check("out_valid", out_valid, 1);
      check("out_class", out_class, ecls);
      check("out_max_sum", out_max_sum, emax);
      check("out_err", out_err, e_err);
`ifdef ARGMAX_MARGIN_EN
      check("out_second", out_second, 32'(e_sec[3:0]));
      check("out_margin", out_margin, 32'(e_mar[13:0]));
`else
      check("out_second", out_second, 0);
      check("out_margin", out_margin, 0);
`endif
      if (do_rst) begin
         rst = 1'b1;
         @(posedge clk); #1;
         check("rst_valid", out_valid, 0);
         check("rst_in_ready", in_ready, 0);
         check("rst_outs", {out_class, out_second, out_max_sum, out_margin, out_err}, 0);
         rst = 1'b0;
         @(posedge clk); #1;
         check("rst_release_rdy", in_ready, 1);
         out_ready = 1'b1;
         return;
      end
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         check("hold_valid", out_valid, 1);
         check("hold_class", out_class, ecls);
         check("hold_max", out_max_sum, emax);
         check("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("done_valid", out_valid, 0);
      check("done_in_ready", in_ready, 1);
   endtask

   initial begin
      int t1 [12];
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      cfg_num_class = 5'd0; in_sum = '0; in_idx = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_in_ready", in_ready, 0);
      check("reset_valid", out_valid, 0);
      check("reset_outs", {out_class, out_second, out_max_sum, out_margin, out_err}, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("reset_release_rdy", in_ready, 1);

      t1 = '{-5, 3, 9, 9, -8192, 2, 0, 1, 1, 8, -1, 4};
      for (int k = 0; k < 12; k++) begin f_sum[k] = 14'(t1[k]); f_idx[k] = 4'(k); end
      run_frame(12, 0, 0);

      for (int k = 0; k < 4; k++) begin f_sum[k] = 14'h2000; f_idx[k] = 4'(k); end
      run_frame(4, 0, 0);

      f_sum[0] = 14'h1fff; f_sum[1] = 14'h2000; f_sum[2] = 14'h0000;
      for (int k = 0; k < 3; k++) f_idx[k] = 4'(k);
      run_frame(3, 5, 0);

      fill(4, 0);
      f_idx[2] = 4'd3;
      run_frame(4, 1, 0);
      fill(4, 0);
      run_frame(4, 0, 0);

      // Partial frame with a dominant first beat, then flush alongside a junk beat.
      fill(10, 0);
      f_sum[0] = 14'h1fff;
      for (int k = 0; k < 5; k++) beat(10, f_sum[k], f_idx[k]);
      flush = 1'b1; in_valid = 1'b1; in_sum = 14'h1fff; in_idx = 4'd5;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      check("flush_valid", out_valid, 0);
      check("flush_in_ready", in_ready, 1);
      fill(10, 0);
      run_frame(10, 0, 0);

      fill(6, 0);
      run_frame(6, 2, 1);

      fill(2, 0);
      run_frame(1, 0, 0);
      fill(16, 0);
      run_frame(20, 0, 0);

      for (int f = 0; f < 40; f++) begin
         int c;
         c = int'($urandom_range(0, 20));
         fill(clampn(c), ($urandom_range(0, 7) == 0));
         run_frame(c, int'($urandom_range(0, 3)), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
